gemm_issue_ctrl: RTL and testbench

Issue controller for the single-row GEMM functional-unit status table (FUST-G). It sits between dispatch and the GEMM unit: it accepts one dispatched GEMM instruction and tracks its three source tags against writeback broadcasts. Once all operands are ready it issues the instruction to the GEMM unit over a valid/ready handshake, then holds the row until the unit reports completion. It also implements speculative squash on `flush` and clears the speculative mark on `resolved`.

---
 rtl/gemm_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_gemm_issue_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl: single-row GEMM functional-unit status table (FUST-G).
// Holds one dispatched GEMM op, wakes its three source tags on writeback
// broadcasts, issues over valid/ready and holds the row until completion.
// Speculative rows are squashed on flush; resolved clears the spec mark.
// Optional build macro: GEMM_ISSUE_PERF_EN adds saturating stall counters
// perf_op_stall (cycles waiting on operands) and perf_fu_stall (cycles
// issuing while the unit is not ready).
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | row empty, dispatch accepted
// S_WAIT   | row held, waiting on one or more source tags
// S_ISSUE  | operands ready, issue_valid asserted
// S_EXEC   | handed to GEMM unit, waiting for gemm_done
module gemm_issue_ctrl #(
    parameter int TAG_W = 2,
    parameter int REG_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             disp_en,
    input  logic [REG_W-1:0] disp_rd,
    input  logic [REG_W-1:0] disp_rs1,
    input  logic [REG_W-1:0] disp_rs2,
    input  logic [REG_W-1:0] disp_rs3,
    input  logic [TAG_W-1:0] disp_t1,
    input  logic [TAG_W-1:0] disp_t2,
    input  logic [TAG_W-1:0] disp_t3,
    input  logic             disp_spec,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    input  logic             resolved,
    input  logic             gemm_ready,
    input  logic             gemm_done,
    output logic             fust_busy,
    output logic [TAG_W-1:0] fust_t1,
    output logic [TAG_W-1:0] fust_t2,
    output logic [TAG_W-1:0] fust_t3,
    output logic             issue_valid,
    output logic [REG_W-1:0] issue_rd,
    output logic [REG_W-1:0] issue_rs1,
    output logic [REG_W-1:0] issue_rs2,
    output logic [REG_W-1:0] issue_rs3,
`ifdef GEMM_ISSUE_PERF_EN
    output logic [15:0]      perf_op_stall,
    output logic [15:0]      perf_fu_stall,
`endif
    output logic             gemm_kill
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [TAG_W-1:0] t1, t2, t3, t1_nxt, t2_nxt, t3_nxt;
    logic             spec, spec_nxt;
    logic             kill_nxt;
    logic             accept;
    logic             spec_flush;

    // Next-state, tag wakeup and squash decisions for the single row.
    always_comb begin
        state_nxt  = state;
        t1_nxt     = t1;
        t2_nxt     = t2;
        t3_nxt     = t3;
        spec_nxt   = spec & ~resolved;
        kill_nxt   = 1'b0;
        accept     = 1'b0;
        spec_flush = flush & spec;
        case (state)
            S_IDLE: begin
                // A speculative dispatch that is flushed in the same cycle never enters the row.
                if (disp_en && !(flush && disp_spec)) begin
                    accept    = 1'b1;
                    t1_nxt    = (wb_valid && wb_tag == disp_t1) ? '0 : disp_t1;
                    t2_nxt    = (wb_valid && wb_tag == disp_t2) ? '0 : disp_t2;
                    t3_nxt    = (wb_valid && wb_tag == disp_t3) ? '0 : disp_t3;
                    spec_nxt  = disp_spec & ~resolved;
                    state_nxt = (t1_nxt == '0 && t2_nxt == '0 && t3_nxt == '0) ? S_ISSUE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (spec_flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    if (wb_valid && t1 != '0 && wb_tag == t1) t1_nxt = '0;
                    if (wb_valid && t2 != '0 && wb_tag == t2) t2_nxt = '0;
                    if (wb_valid && t3 != '0 && wb_tag == t3) t3_nxt = '0;
                    if (t1_nxt == '0 && t2_nxt == '0 && t3_nxt == '0) state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A transfer in the flush cycle already reached the unit, so it must be killed.
                if (spec_flush) begin
                    state_nxt = S_IDLE;
                    kill_nxt  = gemm_ready;
                end else if (gemm_ready) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (gemm_done) begin
                    state_nxt = S_IDLE;
                end else if (spec_flush) begin
                    state_nxt = S_IDLE;
                    kill_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_IDLE) begin
            t1_nxt   = '0;
            t2_nxt   = '0;
            t3_nxt   = '0;
            spec_nxt = 1'b0;
        end
    end

    // Row state and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            t1          <= '0;
            t2          <= '0;
            t3          <= '0;
            spec        <= 1'b0;
            issue_rd    <= '0;
            issue_rs1   <= '0;
            issue_rs2   <= '0;
            issue_rs3   <= '0;
            fust_busy   <= 1'b0;
            issue_valid <= 1'b0;
            gemm_kill   <= 1'b0;
        end else begin
            state       <= state_nxt;
            t1          <= t1_nxt;
            t2          <= t2_nxt;
            t3          <= t3_nxt;
            spec        <= spec_nxt;
            fust_busy   <= (state_nxt != S_IDLE);
            issue_valid <= (state_nxt == S_ISSUE);
            gemm_kill   <= kill_nxt;
            if (accept) begin
                issue_rd  <= disp_rd;
                issue_rs1 <= disp_rs1;
                issue_rs2 <= disp_rs2;
                issue_rs3 <= disp_rs3;
            end
        end
    end

    assign fust_t1 = t1;
    assign fust_t2 = t2;
    assign fust_t3 = t3;

`ifdef GEMM_ISSUE_PERF_EN
    // Saturating stall counters: operand wait and unit back-pressure.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_op_stall <= '0;
            perf_fu_stall <= '0;
        end else begin
            if (state == S_WAIT && perf_op_stall != 16'hFFFF)
                perf_op_stall <= perf_op_stall + 16'd1;
            if (state == S_ISSUE && !gemm_ready && perf_fu_stall != 16'hFFFF)
                perf_fu_stall <= perf_fu_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// Testbench for gemm_issue_ctrl: directed scenarios plus a randomized run
// checked against an occupancy/issued/tag model of the row.
module tb_gemm_issue_ctrl;

    localparam int TAG_W = 2;
    localparam int REG_W = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             disp_en;
    logic [REG_W-1:0] disp_rd, disp_rs1, disp_rs2, disp_rs3;
    logic [TAG_W-1:0] disp_t1, disp_t2, disp_t3;
    logic             disp_spec;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             flush, resolved, gemm_ready, gemm_done;
    logic             fust_busy;
    logic [TAG_W-1:0] fust_t1, fust_t2, fust_t3;
    logic             issue_valid;
    logic [REG_W-1:0] issue_rd, issue_rs1, issue_rs2, issue_rs3;
    logic             gemm_kill;
`ifdef GEMM_ISSUE_PERF_EN
    logic [15:0]      perf_op_stall, perf_fu_stall;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: is the row occupied, has it been handed to the unit,
    // which tags are still outstanding, and the captured registers.
    logic             m_occ, m_issued, m_spec, m_kill;
    logic [TAG_W-1:0] m_tag [3];
    logic [REG_W-1:0] m_rd, m_rs1, m_rs2, m_rs3;

    gemm_issue_ctrl #(.TAG_W(TAG_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .disp_en(disp_en), .disp_rd(disp_rd), .disp_rs1(disp_rs1),
        .disp_rs2(disp_rs2), .disp_rs3(disp_rs3),
        .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_t3(disp_t3),
        .disp_spec(disp_spec), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .flush(flush), .resolved(resolved),
        .gemm_ready(gemm_ready), .gemm_done(gemm_done),
        .fust_busy(fust_busy), .fust_t1(fust_t1), .fust_t2(fust_t2), .fust_t3(fust_t3),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
`ifdef GEMM_ISSUE_PERF_EN
        .perf_op_stall(perf_op_stall), .perf_fu_stall(perf_fu_stall),
`endif
        .gemm_kill(gemm_kill)
    );

    always #5 CLK = ~CLK;

    // Dispatch is only legal while the row is free.
    always @(posedge CLK) begin
        if (nRST) assert (!(disp_en && fust_busy)) else $error("dispatch while busy");
    end

    task automatic model_reset();
        m_occ = 0; m_issued = 0; m_spec = 0; m_kill = 0;
        for (int i = 0; i < 3; i++) m_tag[i] = '0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_rs3 = '0;
    endtask

    function automatic logic exp_iv();
        return m_occ && !m_issued && m_tag[0] == '0 && m_tag[1] == '0 && m_tag[2] == '0;
    endfunction

    task automatic model_update();
        logic [TAG_W-1:0] dt [3];
        logic ready_now;
        if (!nRST) begin
            model_reset();
            return;
        end
        m_kill = 0;
        if (!m_occ) begin
            if (disp_en && !(flush && disp_spec)) begin
                dt[0] = disp_t1; dt[1] = disp_t2; dt[2] = disp_t3;
                for (int i = 0; i < 3; i++) m_tag[i] = (wb_valid && wb_tag == dt[i]) ? '0 : dt[i];
                m_rd = disp_rd; m_rs1 = disp_rs1; m_rs2 = disp_rs2; m_rs3 = disp_rs3;
                m_spec = disp_spec && !resolved;
                m_occ = 1; m_issued = 0;
            end
        end else begin
            ready_now = exp_iv();
            if (m_issued && gemm_done) begin
                m_occ = 0;
            end else if (flush && m_spec) begin
                if (m_issued || (ready_now && gemm_ready)) m_kill = 1;
                m_occ = 0;
            end else begin
                if (ready_now && gemm_ready) m_issued = 1;
                else if (!m_issued && wb_valid && wb_tag != '0)
                    for (int i = 0; i < 3; i++) if (m_tag[i] == wb_tag) m_tag[i] = '0;
                if (resolved) m_spec = 0;
            end
            if (!m_occ) begin
                m_issued = 0; m_spec = 0;
                for (int i = 0; i < 3; i++) m_tag[i] = '0;
            end
        end
    endtask

    // One clock: model follows the edge, return at the falling edge for sampling.
    task automatic step();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        disp_en = 0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0; disp_rs3 = '0;
        disp_t1 = '0; disp_t2 = '0; disp_t3 = '0; disp_spec = 0;
        wb_valid = 0; wb_tag = '0; flush = 0; resolved = 0;
        gemm_ready = 0; gemm_done = 0;
    endtask

    task automatic dispatch(input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2,
                            input logic [3:0] r3, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] c, input logic sp);
        disp_en = 1; disp_rd = rd; disp_rs1 = r1; disp_rs2 = r2; disp_rs3 = r3;
        disp_t1 = a; disp_t2 = b; disp_t3 = c; disp_spec = sp;
    endtask

    // Hand over the issued op and complete it, leaving the row idle.
    task automatic drain();
        gemm_ready = 1; step(); gemm_ready = 0;
        step();
        gemm_done = 1; step(); gemm_done = 0;
    endtask

    task automatic test_reset();
        nRST = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({fust_busy, issue_valid, gemm_kill, fust_t1, fust_t2, fust_t3} !== '0) begin
            errors++;
            $display("FAIL reset_status: got %b required 0", {fust_busy, issue_valid, gemm_kill, fust_t1, fust_t2, fust_t3});
        end
        checks++;
        if ({issue_rd, issue_rs1, issue_rs2, issue_rs3} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h required 0", {issue_rd, issue_rs1, issue_rs2, issue_rs3});
        end
        nRST = 1;
        step();
    endtask

    task automatic test_back_to_back();
        dispatch(4'd3, 4'd1, 4'd2, 4'd4, 2'd0, 2'd0, 2'd0, 1'b0);
        step();
        disp_en = 0;
        checks++;
        if (issue_valid !== 1'b1 || fust_busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_issue: valid=%b busy=%b required 1 1", issue_valid, fust_busy);
        end
        checks++;
        if ({issue_rd, issue_rs1, issue_rs2, issue_rs3} !== 16'h3124) begin
            errors++;
            $display("FAIL ready_regs: got %h required 3124", {issue_rd, issue_rs1, issue_rs2, issue_rs3});
        end
        gemm_ready = 1; step(); gemm_ready = 0;
        checks++;
        if (issue_valid !== 1'b0 || fust_busy !== 1'b1) begin
            errors++;
            $display("FAIL handshake: valid=%b busy=%b required 0 1", issue_valid, fust_busy);
        end
        step(); step();
        gemm_done = 1; step(); gemm_done = 0;
        checks++;
        if (fust_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: busy=%b required 0", fust_busy);
        end
        dispatch(4'd9, 4'd8, 4'd7, 4'd6, 2'd0, 2'd0, 2'd0, 1'b0);
        step();
        disp_en = 0;
        checks++;
        if (fust_busy !== 1'b1 || issue_valid !== 1'b1 || issue_rd !== 4'd9) begin
            errors++;
            $display("FAIL redispatch: busy=%b valid=%b rd=%0d required 1 1 9", fust_busy, issue_valid, issue_rd);
        end
        drain();
    endtask

    task automatic test_tag_wakeup();
        dispatch(4'd5, 4'd6, 4'd7, 4'd8, 2'd1, 2'd2, 2'd3, 1'b0);
        step();
        disp_en = 0;
        checks++;
        if ({fust_t1, fust_t2, fust_t3, issue_valid} !== {2'd1, 2'd2, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL wake_capture: tags=%0d/%0d/%0d valid=%b required 1/2/3 0", fust_t1, fust_t2, fust_t3, issue_valid);
        end
        wb_valid = 1; wb_tag = 2'd2; step();
        checks++;
        if ({fust_t1, fust_t2, fust_t3, issue_valid} !== {2'd1, 2'd0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL wake_t2: tags=%0d/%0d/%0d valid=%b required 1/0/3 0", fust_t1, fust_t2, fust_t3, issue_valid);
        end
        wb_tag = 2'd1; step();
        checks++;
        if ({fust_t1, fust_t2, fust_t3, issue_valid} !== {2'd0, 2'd0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL wake_t1: tags=%0d/%0d/%0d valid=%b required 0/0/3 0", fust_t1, fust_t2, fust_t3, issue_valid);
        end
        wb_tag = 2'd3; step();
        wb_valid = 0; wb_tag = '0;
        checks++;
        if ({fust_t1, fust_t2, fust_t3, issue_valid} !== {2'd0, 2'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL wake_issue: tags=%0d/%0d/%0d valid=%b required 0/0/0 1", fust_t1, fust_t2, fust_t3, issue_valid);
        end
        drain();
    endtask

    task automatic test_bypass();
        dispatch(4'd1, 4'd2, 4'd3, 4'd4, 2'd2, 2'd0, 2'd0, 1'b0);
        wb_valid = 1; wb_tag = 2'd2;
        step();
        disp_en = 0; wb_valid = 0; wb_tag = '0;
        checks++;
        if (fust_t1 !== 2'd0 || issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass: t1=%0d valid=%b required 0 1", fust_t1, issue_valid);
        end
        drain();
    endtask

    task automatic test_fu_stall();
        logic [15:0] regs0;
`ifdef GEMM_ISSUE_PERF_EN
        logic [15:0] base;
`endif
        dispatch(4'hA, 4'hB, 4'hC, 4'hD, 2'd0, 2'd0, 2'd0, 1'b0);
        step();
        disp_en = 0;
        regs0 = {issue_rd, issue_rs1, issue_rs2, issue_rs3};
`ifdef GEMM_ISSUE_PERF_EN
        base = perf_fu_stall;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (issue_valid !== 1'b1 || {issue_rd, issue_rs1, issue_rs2, issue_rs3} !== 16'hABCD) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b regs=%h required 1 abcd (first %h)", i, issue_valid,
                         {issue_rd, issue_rs1, issue_rs2, issue_rs3}, regs0);
            end
        end
`ifdef GEMM_ISSUE_PERF_EN
        checks++;
        if (perf_fu_stall - base !== 16'd4) begin
            errors++;
            $display("FAIL perf_fu_stall: delta=%0d required 4", perf_fu_stall - base);
        end
`endif
        drain();
    endtask

    task automatic test_flush();
        dispatch(4'd2, 4'd3, 4'd4, 4'd5, 2'd0, 2'd0, 2'd0, 1'b1);
        step();
        disp_en = 0;
        gemm_ready = 1; step(); gemm_ready = 0;
        flush = 1; step(); flush = 0;
        checks++;
        if (gemm_kill !== 1'b1 || fust_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_exec: kill=%b busy=%b required 1 0", gemm_kill, fust_busy);
        end
        step();
        checks++;
        if (gemm_kill !== 1'b0) begin
            errors++;
            $display("FAIL kill_pulse: kill=%b required 0", gemm_kill);
        end
        dispatch(4'd2, 4'd3, 4'd4, 4'd5, 2'd0, 2'd0, 2'd0, 1'b0);
        step();
        disp_en = 0;
        flush = 1; step(); flush = 0;
        checks++;
        if (fust_busy !== 1'b1 || issue_valid !== 1'b1 || gemm_kill !== 1'b0) begin
            errors++;
            $display("FAIL flush_nonspec: busy=%b valid=%b kill=%b required 1 1 0", fust_busy, issue_valid, gemm_kill);
        end
        drain();
        dispatch(4'd6, 4'd6, 4'd6, 4'd6, 2'd1, 2'd0, 2'd0, 1'b1);
        step();
        disp_en = 0;
        resolved = 1; step(); resolved = 0;
        flush = 1; step(); flush = 0;
        checks++;
        if (fust_busy !== 1'b1 || fust_t1 !== 2'd1) begin
            errors++;
            $display("FAIL flush_resolved: busy=%b t1=%0d required 1 1", fust_busy, fust_t1);
        end
        wb_valid = 1; wb_tag = 2'd1; step(); wb_valid = 0; wb_tag = '0;
        drain();
    endtask

    task automatic test_async_reset();
        dispatch(4'd7, 4'd1, 4'd1, 4'd1, 2'd1, 2'd2, 2'd3, 1'b0);
        step();
        disp_en = 0;
        #2 nRST = 0;
        #1;
        checks++;
        if ({fust_busy, issue_valid, gemm_kill, fust_t1, fust_t2, fust_t3} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {fust_busy, issue_valid, gemm_kill, fust_t1, fust_t2, fust_t3});
        end
        model_reset();
        @(negedge CLK);
        nRST = 1;
        dispatch(4'd4, 4'd3, 4'd2, 4'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        step();
        disp_en = 0;
        checks++;
        if (issue_valid !== 1'b1 || {issue_rd, issue_rs1, issue_rs2, issue_rs3} !== 16'h4321) begin
            errors++;
            $display("FAIL post_reset: valid=%b regs=%h required 1 4321", issue_valid, {issue_rd, issue_rs1, issue_rs2, issue_rs3});
        end
        drain();
    endtask

    task automatic test_random();
        logic [3+3*TAG_W-1:0] obs, exp;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            disp_en    = !m_occ && ($urandom_range(0, 1) == 1);
            disp_rd    = REG_W'($urandom); disp_rs1 = REG_W'($urandom);
            disp_rs2   = REG_W'($urandom); disp_rs3 = REG_W'($urandom);
            disp_t1    = TAG_W'($urandom); disp_t2 = TAG_W'($urandom); disp_t3 = TAG_W'($urandom);
            disp_spec  = $urandom_range(0, 1) == 1;
            wb_valid   = $urandom_range(0, 1) == 1;
            wb_tag     = TAG_W'($urandom);
            flush      = $urandom_range(0, 11) == 0;
            resolved   = $urandom_range(0, 7) == 0;
            gemm_ready = $urandom_range(0, 2) == 0;
            gemm_done  = $urandom_range(0, 3) == 0;
            step();
            exp = {m_occ, exp_iv(), m_kill, m_tag[0], m_tag[1], m_tag[2]};
            obs = {fust_busy, issue_valid, gemm_kill, fust_t1, fust_t2, fust_t3};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_status cyc %0d: got %b required %b (busy valid kill t1 t2 t3)", cyc, obs, exp);
            end
            if (exp_iv()) begin
                checks++;
                if ({issue_rd, issue_rs1, issue_rs2, issue_rs3} !== {m_rd, m_rs1, m_rs2, m_rs3}) begin
                    errors++;
                    $display("FAIL random_regs cyc %0d: got %h required %h", cyc,
                             {issue_rd, issue_rs1, issue_rs2, issue_rs3}, {m_rd, m_rs1, m_rs2, m_rs3});
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_tag_wakeup();
        test_bypass();
        test_fu_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
